dma_ch_reg_file: RTL and testbench
==================================

Name: dma_ch_reg_file

Overview:
- Multi-channel DMA register file: CPU-side register bank for NUM_CH independent DMA channels.
- Per channel: control, length, source-address and destination-address registers.
- Global status, sticky done and error registers, plus one interrupt output.
- Sits between the CPU control bus and the per-channel DMA transfer engines.
- Drives start/abort pulses to each engine; receives done pulses back.

Parameters:
- WIDTH, 8: data and register width; must be >= NUM_CH.
- NUM_CH, 4: number of channels, 1..8.
- ADDR_W, 8: control address width; must hold 4*NUM_CH+3.

Ports:
- clk, input, 1: clock.
- arst_n, input, 1: reset, asynchronous, active-high.
- ctrl_data, input, WIDTH: write data.
- ctrl_addr, input, ADDR_W: register address.
- ctrl_RD_en, input, 1: read strobe.
- ctrl_WR_en, input, 1: write strobe.
- Rdata, output, WIDTH: registered read data.
- rd_valid, output, 1: Rdata valid pulse.
- ch_start, output, NUM_CH: one-cycle start pulse per channel.
- ch_abort, output, NUM_CH: one-cycle abort pulse per channel.
- ch_done_in, input, NUM_CH: engine completion pulse per channel.
- ch_len, output, NUM_CH*WIDTH: lengths, channel c at bits [c*WIDTH +: WIDTH].
- ch_src, output, NUM_CH*WIDTH: source addresses, same packing.
- ch_dst, output, NUM_CH*WIDTH: destination addresses, same packing.
- ch_busy, output, NUM_CH: channel busy flags.
- irq, output, 1: registered interrupt.

Behaviour:
- Reset (arst_n=1, async): all registers, Rdata, rd_valid, ch_start, ch_abort, ch_busy and irq = 0.
- Address map, channel c:
  - base 4c+0 CTRL: bit0 START (write-only, reads 0), bit1 IRQ_EN, bit2 ABORT (write-only, reads 0).
  - 4c+1 LEN; 4c+2 SRC; 4c+3 DST.
- Global registers:
  - 4N+0 STATUS: busy bits, read-only.
  - 4N+1 DONE: sticky, write-1-to-clear.
  - 4N+2 ERR: sticky, write-1-to-clear.
  - Bits >= NUM_CH read 0.
- Unmapped addresses: reads return 0 with rd_valid; writes are ignored.
- Read: Rdata and rd_valid are updated 1 cycle after the ctrl_RD_en cycle. Rdata holds its value otherwise; rd_valid pulses one cycle.
- RD and WR in the same cycle: both are served. Rdata returns the pre-write value.
- Write to CTRL with START=1 while channel idle:
  - ch_start[c]=1 for exactly the next cycle.
  - ch_busy[c] set in the same edge.
- Write to CTRL with START=1 while ch_busy[c]=1: no pulse; ERR[c] set.
- Write to CTRL with ABORT=1 while busy: ch_abort[c] pulses one cycle; ch_busy[c] clears. If idle, ignored.
- START and ABORT both 1 in one write: ABORT wins; no start.
- IRQ_EN is updated on every CTRL write.
- ch_done_in[c]=1: clears ch_busy[c] and sets DONE[c] at the next edge. Done while idle sets DONE[c] only.
- DONE/ERR clear and set of the same bit in the same cycle: set wins.
- irq = OR over c of (DONE[c] & IRQ_EN[c]) | (ERR[c] & IRQ_EN[c]), registered. It asserts 1 cycle after the DONE/ERR bit is set.
- LEN/SRC/DST are writable at any time; outputs reflect them directly from the register.
- Reset mid-transfer: busy, sticky bits and all pulses drop immediately.

Optional Feature:
- Macro DMA_REG_LOCK_EN.
- Defined: writes to LEN/SRC/DST of a busy channel are ignored and set ERR[c].
- Undefined: those writes always take effect, with no error.

Test Plan:
- Reset, then read every address 0x00-0x13 (WIDTH=8, NUM_CH=4) -> all Rdata=0x00, rd_valid 1 cycle after each strobe.
- Write ch2 LEN=0x20, SRC=0x40, DST=0x80 (addr 0x09, 0x0A, 0x0B), read back -> same values; ch_len[23:16]=0x20.
- Write 0x03 to 0x08 -> ch_start[2] pulses 1 cycle, STATUS(0x10)=0x04. Pulse ch_done_in[2] -> DONE(0x11)=0x04, STATUS=0x00, irq=1 next cycle. Write 0x04 to 0x11 -> DONE=0, irq=0.
- Start ch0 (0x01 to 0x00), start again while busy -> no second pulse, ERR(0x12)=0x01. Write 0x04 to 0x00 -> ch_abort[0] pulse, STATUS=0x00.
- Same-cycle ch_done_in[1] and W1C 0x02 to 0x11 -> DONE[1]=1. Same-cycle RD and WR of 0x05 with 0x55 over old 0x11 -> Rdata=0x11, then re-read gives 0x55.
- Assert arst_n while ch3 busy with irq high -> ch_busy, irq, DONE, ERR = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dma_ch_reg_file.sv
// dma_ch_reg_file: CPU-side register bank for NUM_CH DMA channels.
// Per channel CTRL/LEN/SRC/DST registers, global STATUS/DONE/ERR, one irq.
// Optional build macro DMA_REG_LOCK_EN: when defined, writes to LEN/SRC/DST
// of a busy channel are dropped and flag ERR for that channel.
module dma_ch_reg_file #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic [WIDTH-1:0]          ctrl_data,
   input  logic [ADDR_W-1:0]         ctrl_addr,
   input  logic                      ctrl_RD_en,
   input  logic                      ctrl_WR_en,
   output logic [WIDTH-1:0]          Rdata,
   output logic                      rd_valid,
   output logic [NUM_CH-1:0]         ch_start,
   output logic [NUM_CH-1:0]         ch_abort,
   input  logic [NUM_CH-1:0]         ch_done_in,
   output logic [NUM_CH*WIDTH-1:0]   ch_len,
   output logic [NUM_CH*WIDTH-1:0]   ch_src,
   output logic [NUM_CH*WIDTH-1:0]   ch_dst,
   output logic [NUM_CH-1:0]         ch_busy,
   output logic                      irq
);

   localparam int unsigned CH_BITS = NUM_CH * WIDTH;
   localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(4 * NUM_CH);
   localparam logic [ADDR_W-1:0] DONE_ADDR   = ADDR_W'(4 * NUM_CH + 1);
   localparam logic [ADDR_W-1:0] ERR_ADDR    = ADDR_W'(4 * NUM_CH + 2);

   logic [NUM_CH-1:0]  irq_en_q, irq_en_d;
   logic [NUM_CH-1:0]  busy_q,   busy_d;
   logic [NUM_CH-1:0]  done_q,   done_d;
   logic [NUM_CH-1:0]  err_q,    err_d;
   logic [NUM_CH-1:0]  start_q,  start_d;
   logic [NUM_CH-1:0]  abort_q,  abort_d;
   logic [CH_BITS-1:0] len_q,    len_d;
   logic [CH_BITS-1:0] src_q,    src_d;
   logic [CH_BITS-1:0] dst_q,    dst_d;
   logic [WIDTH-1:0]   rdata_q,  rdata_d;
   logic               rd_valid_q, rd_valid_d;
   logic               irq_q,    irq_d;
   logic [WIDTH-1:0]   rd_mux_c;
   logic [NUM_CH-1:0]  wr_lock_c;

   // Channel parameter registers are write-protected while busy only in lock builds
`ifdef DMA_REG_LOCK_EN
   assign wr_lock_c = busy_q;
`else
   assign wr_lock_c = '0;
`endif

   // Read mux over the pre-write register state
   always_comb begin
      rd_mux_c = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ctrl_addr == ADDR_W'(4 * c))     rd_mux_c = WIDTH'({irq_en_q[c], 1'b0});
         if (ctrl_addr == ADDR_W'(4 * c + 1)) rd_mux_c = len_q[c*WIDTH +: WIDTH];
         if (ctrl_addr == ADDR_W'(4 * c + 2)) rd_mux_c = src_q[c*WIDTH +: WIDTH];
         if (ctrl_addr == ADDR_W'(4 * c + 3)) rd_mux_c = dst_q[c*WIDTH +: WIDTH];
      end
      if (ctrl_addr == STATUS_ADDR) rd_mux_c = WIDTH'(busy_q);
      if (ctrl_addr == DONE_ADDR)   rd_mux_c = WIDTH'(done_q);
      if (ctrl_addr == ERR_ADDR)    rd_mux_c = WIDTH'(err_q);
   end

   // Next-state: reads, register writes, start/abort/done handling, irq
   always_comb begin
      rdata_d    = rdata_q;
      rd_valid_d = ctrl_RD_en;
      irq_en_d   = irq_en_q;
      len_d      = len_q;
      src_d      = src_q;
      dst_d      = dst_q;
      start_d    = '0;
      abort_d    = '0;
      busy_d     = busy_q & ~ch_done_in;
      done_d     = done_q;
      err_d      = err_q;
      irq_d      = |((done_q | err_q) & irq_en_q);

      if (ctrl_RD_en) rdata_d = rd_mux_c;

      // Write-1-to-clear first so that a same-cycle set below wins
      if (ctrl_WR_en && (ctrl_addr == DONE_ADDR)) done_d = done_q & ~ctrl_data[NUM_CH-1:0];
      if (ctrl_WR_en && (ctrl_addr == ERR_ADDR))  err_d  = err_q  & ~ctrl_data[NUM_CH-1:0];
      done_d = done_d | ch_done_in;

      if (ctrl_WR_en) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ctrl_addr == ADDR_W'(4 * c)) begin
               irq_en_d[c] = ctrl_data[1];
               if (ctrl_data[2]) begin
                  // Abort takes priority over start; idle abort is a no-op
                  if (busy_q[c]) begin
                     abort_d[c] = 1'b1;
                     busy_d[c]  = 1'b0;
                  end
               end else if (ctrl_data[0]) begin
                  if (busy_q[c]) begin
                     err_d[c] = 1'b1;
                  end else begin
                     start_d[c] = 1'b1;
                     busy_d[c]  = 1'b1;
                  end
               end
            end
            if (ctrl_addr == ADDR_W'(4 * c + 1)) begin
               if (wr_lock_c[c]) err_d[c] = 1'b1;
               else              len_d[c*WIDTH +: WIDTH] = ctrl_data;
            end
            if (ctrl_addr == ADDR_W'(4 * c + 2)) begin
               if (wr_lock_c[c]) err_d[c] = 1'b1;
               else              src_d[c*WIDTH +: WIDTH] = ctrl_data;
            end
            if (ctrl_addr == ADDR_W'(4 * c + 3)) begin
               if (wr_lock_c[c]) err_d[c] = 1'b1;
               else              dst_d[c*WIDTH +: WIDTH] = ctrl_data;
            end
         end
      end
   end

   // State registers, asynchronously cleared while arst_n is high
   always_ff @(posedge clk or posedge arst_n) begin
      if (arst_n) begin
         irq_en_q   <= '0;
         busy_q     <= '0;
         done_q     <= '0;
         err_q      <= '0;
         start_q    <= '0;
         abort_q    <= '0;
         len_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         irq_en_q   <= irq_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         start_q    <= start_d;
         abort_q    <= abort_d;
         len_q      <= len_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         rdata_q    <= rdata_d;
         rd_valid_q <= rd_valid_d;
         irq_q      <= irq_d;
      end
   end

   assign Rdata    = rdata_q;
   assign rd_valid = rd_valid_q;
   assign ch_start = start_q;
   assign ch_abort = abort_q;
   assign ch_busy  = busy_q;
   assign ch_len   = len_q;
   assign ch_src   = src_q;
   assign ch_dst   = dst_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_dma_ch_reg_file.sv
// tb_dma_ch_reg_file: directed and randomized checks of dma_ch_reg_file
// (WIDTH=8, NUM_CH=4) against a behavioural register-file model.
module tb_dma_ch_reg_file;

   logic        clk;
   logic        arst_n;
   logic [7:0]  ctrl_data;
   logic [7:0]  ctrl_addr;
   logic        ctrl_RD_en;
   logic        ctrl_WR_en;
   logic [7:0]  Rdata;
   logic        rd_valid;
   logic [3:0]  ch_start;
   logic [3:0]  ch_abort;
   logic [3:0]  ch_done_in;
   logic [31:0] ch_len;
   logic [31:0] ch_src;
   logic [31:0] ch_dst;
   logic [3:0]  ch_busy;
   logic        irq;

   int checks = 0;
   int errors = 0;

   dma_ch_reg_file #(.WIDTH(8), .NUM_CH(4), .ADDR_W(8)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .ctrl_data  (ctrl_data),
      .ctrl_addr  (ctrl_addr),
      .ctrl_RD_en (ctrl_RD_en),
      .ctrl_WR_en (ctrl_WR_en),
      .Rdata      (Rdata),
      .rd_valid   (rd_valid),
      .ch_start   (ch_start),
      .ch_abort   (ch_abort),
      .ch_done_in (ch_done_in),
      .ch_len     (ch_len),
      .ch_src     (ch_src),
      .ch_dst     (ch_dst),
      .ch_busy    (ch_busy),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: register contents per channel and global flags
   bit [7:0] m_len [4];
   bit [7:0] m_src [4];
   bit [7:0] m_dst [4];
   bit [3:0] m_ien, m_busy, m_done, m_err;
   bit       m_irq;
   bit [7:0] exp_rdata;
   bit       exp_rv;
   bit [3:0] exp_start, exp_abort;

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_len[c] = 0; m_src[c] = 0; m_dst[c] = 0;
      end
      m_ien = 0; m_busy = 0; m_done = 0; m_err = 0; m_irq = 0;
      exp_rdata = 0; exp_rv = 0; exp_start = 0; exp_abort = 0;
   endtask

   function automatic bit [7:0] model_read(input bit [7:0] a);
      int c;
      c = int'(a) / 4;
      if (a < 8'd16) begin
         case (a % 4)
            0: return {6'd0, m_ien[c], 1'b0};
            1: return m_len[c];
            2: return m_src[c];
            default: return m_dst[c];
         endcase
      end
      if (a == 8'h10) return {4'd0, m_busy};
      if (a == 8'h11) return {4'd0, m_done};
      if (a == 8'h12) return {4'd0, m_err};
      return 8'h00;
   endfunction

   // Advance the model by one clock edge for the given bus activity
   task automatic model_step(input bit rd, input bit wr, input bit [7:0] a,
                             input bit [7:0] d, input bit [3:0] dn);
      bit [3:0] was_busy;
      bit       irq_next;
      int       c;
      bit       locked;
      was_busy = m_busy;
      irq_next = |((m_done | m_err) & m_ien);
      exp_start = 0;
      exp_abort = 0;
      exp_rv = rd;
      if (rd) exp_rdata = model_read(a);
      m_busy = m_busy & ~dn;
      if (wr && a == 8'h11) m_done = m_done & ~d[3:0];
      if (wr && a == 8'h12) m_err  = m_err  & ~d[3:0];
      m_done = m_done | dn;
      if (wr && a < 8'd16) begin
         c = int'(a) / 4;
`ifdef DMA_REG_LOCK_EN
         locked = was_busy[c];
`else
         locked = 0;
`endif
         case (a % 4)
            0: begin
               m_ien[c] = d[1];
               if (d[2]) begin
                  if (was_busy[c]) begin exp_abort[c] = 1; m_busy[c] = 0; end
               end else if (d[0]) begin
                  if (was_busy[c]) m_err[c] = 1;
                  else begin exp_start[c] = 1; m_busy[c] = 1; end
               end
            end
            1: if (locked) m_err[c] = 1; else m_len[c] = d;
            2: if (locked) m_err[c] = 1; else m_src[c] = d;
            default: if (locked) m_err[c] = 1; else m_dst[c] = d;
         endcase
      end
      m_irq = irq_next;
   endtask

   // One clock of bus activity; outputs are stable at return (1 time unit after the edge)
   task automatic drive(input bit rd, input bit wr, input bit [7:0] a,
                        input bit [7:0] d, input bit [3:0] dn);
      ctrl_RD_en = rd; ctrl_WR_en = wr; ctrl_addr = a; ctrl_data = d; ch_done_in = dn;
      model_step(rd, wr, a, d, dn);
      @(posedge clk);
      #1;
      ctrl_RD_en = 0; ctrl_WR_en = 0; ctrl_addr = 0; ctrl_data = 0; ch_done_in = 0;
   endtask

   task automatic test_reset();
      arst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({Rdata, rd_valid, ch_start, ch_abort, ch_busy, irq} !== 22'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0", {Rdata, rd_valid, ch_start, ch_abort, ch_busy, irq});
      end
      checks++;
      if ({ch_len, ch_src, ch_dst} !== 96'd0) begin
         errors++;
         $display("FAIL reset_regs got %h exp 0", {ch_len, ch_src, ch_dst});
      end
      arst_n = 1'b0;
      model_reset();
      for (int a = 0; a <= 8'h13; a++) begin
         drive(1, 0, 8'(a), 8'h00, 4'h0);
         checks++;
         if (rd_valid !== 1'b1 || Rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_read addr %h got rv=%b data=%h exp rv=1 data=00", a, rd_valid, Rdata);
         end
      end
      drive(0, 0, 8'h00, 8'h00, 4'h0);
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid_pulse got %b exp 0", rd_valid);
      end
   endtask

   task automatic test_regs();
      drive(0, 1, 8'h09, 8'h20, 4'h0);
      drive(0, 1, 8'h0A, 8'h40, 4'h0);
      drive(0, 1, 8'h0B, 8'h80, 4'h0);
      checks++;
      if (ch_len[23:16] !== 8'h20 || ch_src[23:16] !== 8'h40 || ch_dst[23:16] !== 8'h80) begin
         errors++;
         $display("FAIL ch2_outputs got len=%h src=%h dst=%h exp 20 40 80",
                  ch_len[23:16], ch_src[23:16], ch_dst[23:16]);
      end
      drive(1, 0, 8'h09, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h20) begin errors++; $display("FAIL read_len2 got %h exp 20", Rdata); end
      drive(1, 0, 8'h0A, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h40) begin errors++; $display("FAIL read_src2 got %h exp 40", Rdata); end
      drive(1, 0, 8'h0B, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h80) begin errors++; $display("FAIL read_dst2 got %h exp 80", Rdata); end
      drive(0, 0, 8'h00, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h80) begin errors++; $display("FAIL rdata_hold got %h exp 80", Rdata); end
   endtask

   task automatic test_start_done();
      drive(0, 1, 8'h08, 8'h03, 4'h0);
      checks++;
      if (ch_start !== 4'b0100 || ch_busy !== 4'b0100) begin
         errors++;
         $display("FAIL start2 got start=%b busy=%b exp 0100 0100", ch_start, ch_busy);
      end
      drive(1, 0, 8'h10, 8'h00, 4'h0);
      checks++;
      if (ch_start !== 4'b0000 || Rdata !== 8'h04) begin
         errors++;
         $display("FAIL start2_after got start=%b status=%h exp 0000 04", ch_start, Rdata);
      end
      drive(0, 0, 8'h00, 8'h00, 4'b0100);
      checks++;
      if (ch_busy !== 4'b0000 || irq !== 1'b0) begin
         errors++;
         $display("FAIL done2 got busy=%b irq=%b exp 0000 0", ch_busy, irq);
      end
      drive(1, 0, 8'h11, 8'h00, 4'h0);
      checks++;
      if (irq !== 1'b1 || Rdata !== 8'h04) begin
         errors++;
         $display("FAIL done2_irq got irq=%b done=%h exp 1 04", irq, Rdata);
      end
      drive(1, 0, 8'h10, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h00) begin errors++; $display("FAIL status_idle got %h exp 00", Rdata); end
      drive(0, 1, 8'h11, 8'h04, 4'h0);
      drive(1, 0, 8'h11, 8'h00, 4'h0);
      checks++;
      if (irq !== 1'b0 || Rdata !== 8'h00) begin
         errors++;
         $display("FAIL done2_clear got irq=%b done=%h exp 0 00", irq, Rdata);
      end
   endtask

   task automatic test_busy_abort();
      drive(0, 1, 8'h00, 8'h01, 4'h0);
      checks++;
      if (ch_start !== 4'b0001) begin errors++; $display("FAIL start0 got %b exp 0001", ch_start); end
      drive(0, 1, 8'h00, 8'h01, 4'h0);
      checks++;
      if (ch_start !== 4'b0000) begin errors++; $display("FAIL restart0 got %b exp 0000", ch_start); end
      drive(1, 0, 8'h12, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h01) begin errors++; $display("FAIL err0 got %h exp 01", Rdata); end
      drive(0, 1, 8'h00, 8'h04, 4'h0);
      checks++;
      if (ch_abort !== 4'b0001 || ch_busy !== 4'b0000) begin
         errors++;
         $display("FAIL abort0 got abort=%b busy=%b exp 0001 0000", ch_abort, ch_busy);
      end
      drive(0, 1, 8'h12, 8'h01, 4'h0);
      checks++;
      if (ch_abort !== 4'b0000) begin errors++; $display("FAIL abort0_pulse got %b exp 0000", ch_abort); end
      drive(0, 1, 8'h04, 8'h05, 4'h0);
      checks++;
      if (ch_start !== 4'b0000 || ch_abort !== 4'b0000 || ch_busy !== 4'b0000) begin
         errors++;
         $display("FAIL start_abort1 got start=%b abort=%b busy=%b exp 0000", ch_start, ch_abort, ch_busy);
      end
   endtask

   task automatic test_w1c_race();
      drive(0, 1, 8'h11, 8'h02, 4'b0010);
      drive(1, 0, 8'h11, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h02) begin errors++; $display("FAIL w1c_race got %h exp 02", Rdata); end
      drive(0, 1, 8'h11, 8'h02, 4'h0);
      drive(1, 0, 8'h11, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h00) begin errors++; $display("FAIL w1c_clear got %h exp 00", Rdata); end
   endtask

   task automatic test_rd_wr_same();
      drive(0, 1, 8'h05, 8'h11, 4'h0);
      drive(1, 1, 8'h05, 8'h55, 4'h0);
      checks++;
      if (Rdata !== 8'h11 || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL rdwr_old got %h rv=%b exp 11 1", Rdata, rd_valid);
      end
      drive(1, 0, 8'h05, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h55) begin errors++; $display("FAIL rdwr_new got %h exp 55", Rdata); end
   endtask

   task automatic test_random();
      bit [31:0] el, es, ed;
      bit [7:0]  a, d;
      bit [3:0]  dn;
      bit        rd, wr;
      for (int i = 0; i < 400; i++) begin
         rd = ($urandom_range(0, 2) == 0);
         wr = ($urandom_range(0, 1) == 0);
         a  = 8'($urandom_range(0, 23));
         if (a[1:0] == 2'b00 && a < 8'd16) d = 8'($urandom_range(0, 7));
         else d = 8'($urandom);
         dn = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
         drive(rd, wr, a, d, dn);
         for (int c = 0; c < 4; c++) begin
            el[c*8 +: 8] = m_len[c];
            es[c*8 +: 8] = m_src[c];
            ed[c*8 +: 8] = m_dst[c];
         end
         checks++;
         if (rd_valid !== exp_rv || Rdata !== exp_rdata) begin
            errors++;
            $display("FAIL rnd_read %0d got rv=%b data=%h exp rv=%b data=%h", i, rd_valid, Rdata, exp_rv, exp_rdata);
         end
         checks++;
         if (ch_start !== exp_start || ch_abort !== exp_abort || ch_busy !== m_busy) begin
            errors++;
            $display("FAIL rnd_ctrl %0d got s=%b a=%b b=%b exp s=%b a=%b b=%b",
                     i, ch_start, ch_abort, ch_busy, exp_start, exp_abort, m_busy);
         end
         checks++;
         if (irq !== m_irq) begin
            errors++;
            $display("FAIL rnd_irq %0d got %b exp %b", i, irq, m_irq);
         end
         checks++;
         if (ch_len !== el || ch_src !== es || ch_dst !== ed) begin
            errors++;
            $display("FAIL rnd_regs %0d got %h %h %h exp %h %h %h", i, ch_len, ch_src, ch_dst, el, es, ed);
         end
      end
   endtask

   task automatic test_async_reset();
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      arst_n = 1'b0;
      model_reset();
      drive(0, 1, 8'h0C, 8'h03, 4'h0);
      drive(0, 1, 8'h0C, 8'h03, 4'h0);
      drive(0, 0, 8'h00, 8'h00, 4'h0);
      checks++;
      if (ch_busy !== 4'b1000 || irq !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset got busy=%b irq=%b exp 1000 1", ch_busy, irq);
      end
      #2;
      arst_n = 1'b1;
      #1;
      checks++;
      if (ch_busy !== 4'b0000 || irq !== 1'b0 || ch_start !== 4'b0000 || ch_abort !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset got busy=%b irq=%b start=%b abort=%b exp all 0", ch_busy, irq, ch_start, ch_abort);
      end
      @(posedge clk);
      #1;
      arst_n = 1'b0;
      model_reset();
      drive(1, 0, 8'h11, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h00) begin errors++; $display("FAIL reset_done got %h exp 00", Rdata); end
      drive(1, 0, 8'h12, 8'h00, 4'h0);
      checks++;
      if (Rdata !== 8'h00) begin errors++; $display("FAIL reset_err got %h exp 00", Rdata); end
   endtask

   initial begin
      ctrl_data = 0; ctrl_addr = 0; ctrl_RD_en = 0; ctrl_WR_en = 0; ch_done_in = 0;
      arst_n = 1'b1;
      test_reset();
      test_regs();
      test_start_done();
      test_busy_abort();
      test_w1c_race();
      test_rd_wr_same();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
